// File: rtl/cube_line_sequencer.sv
// cube_line_sequencer
//
// Frame-level controller for the cube rotation engine. A frame_start walks
// the 12 cube edges through the free-running rotation engine. Each edge index
// is held on line_num long enough for the engine outputs to settle. The
// endpoints are then projected to 640x480 screen space, clamped, and written
// to the non-displayed bank of a double-buffered edge table. At the end of
// the frame the banks swap.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   frame_start           : one-cycle request to compute a frame
//   eng_x0/y0/x1/y1       : signed 13-bit rotated endpoints from the engine
//   line_num              : edge index driven to the engine (0..11)
//   wr_en, wr_addr        : edge-table write strobe, {bank, line index}
//   wr_x0/y0/x1/y1        : projected, clamped endpoints (hold between writes)
//   disp_bank             : bank currently read by the line drawer
//   busy                  : frame in progress (through the DONE cycle)
//   frame_done            : one-cycle pulse on frame completion
//   overrun               : sticky, frame_start seen while busy
module cube_line_sequencer #(
  parameter int SETTLE = 12,
  parameter int SHIFT  = 3,
  parameter int CX     = 320,
  parameter int CY     = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic signed [12:0] eng_x0,
  input  logic signed [12:0] eng_y0,
  input  logic signed [12:0] eng_x1,
  input  logic signed [12:0] eng_y1,
  output logic [3:0]         line_num,
  output logic               wr_en,
  output logic [4:0]         wr_addr,
  output logic [9:0]         wr_x0,
  output logic [9:0]         wr_y0,
  output logic [9:0]         wr_x1,
  output logic [9:0]         wr_y1,
  output logic               disp_bank,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam int CNT_W = $clog2(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [3:0] LAST_LINE = 4'd11;

  // Projection is done at 18 bits so that any 13-bit engine value shifted
  // by SHIFT plus the centre offset cannot wrap before clamping.
  localparam logic signed [17:0] CX_S  = 18'(CX);
  localparam logic signed [17:0] CY_S  = 18'(CY);
  localparam logic signed [17:0] X_MAX = 18'sd639;
  localparam logic signed [17:0] Y_MAX = 18'sd479;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic capture;

  function automatic logic signed [17:0] widen(input logic signed [12:0] e);
    logic signed [17:0] w;
    w = {{5{e[12]}}, e};
    return w;
  endfunction

  function automatic logic [9:0] sat(input logic signed [17:0] v,
                                     input logic signed [17:0] hi);
    logic [9:0] r;
    if (v < 18'sd0)
      r = '0;
    else if (v > hi)
      r = hi[9:0];
    else
      r = v[9:0];
    return r;
  endfunction

  function automatic logic [9:0] proj_x(input logic signed [12:0] e);
    logic signed [17:0] v;
    v = CX_S + (widen(e) <<< SHIFT);
    return sat(v, X_MAX);
  endfunction

  // Screen y grows downward, so engine y is subtracted from the centre.
  function automatic logic [9:0] proj_y(input logic signed [12:0] e);
    logic signed [17:0] v;
    v = CY_S - (widen(e) <<< SHIFT);
    return sat(v, Y_MAX);
  endfunction

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start)
          state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          capture    = 1'b1;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        state_next = (line_num == LAST_LINE) ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign wr_en      = (state == S_WRITE);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      line_num  <= '0;
      disp_bank <= 1'b0;
      overrun   <= 1'b0;
      wr_addr   <= '0;
      wr_x0     <= '0;
      wr_y0     <= '0;
      wr_x1     <= '0;
      wr_y1     <= '0;
    end else begin
      state <= state_next;
      // DONE still counts as busy, so a request there is an overrun too.
      if (frame_start && (state != S_IDLE))
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            line_num <= '0;
            cnt      <= '0;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 1'b1;
          // Engine values at the end of the last settle cycle are projected
          // and registered; they are presented during the WRITE cycle.
          if (capture) begin
            wr_addr <= {~disp_bank, line_num};
            wr_x0   <= proj_x(eng_x0);
            wr_y0   <= proj_y(eng_y0);
            wr_x1   <= proj_x(eng_x1);
            wr_y1   <= proj_y(eng_y1);
          end
        end
        S_WRITE: begin
          if (line_num != LAST_LINE) begin
            line_num <= line_num + 4'd1;
            cnt      <= '0;
          end
        end
        S_DONE: begin
          // Only a completed frame swaps banks; an aborted one never gets here.
          disp_bank <= ~disp_bank;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cube_line_sequencer.sv
// Testbench for cube_line_sequencer: directed frames with a write scoreboard,
// constant and clamping engine stubs, and a behavioural 6-phase engine model.
module tb_cube_line_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic signed [12:0] eng_x0, eng_y0, eng_x1, eng_y1;
  logic [3:0] line_num;
  logic wr_en;
  logic [4:0] wr_addr;
  logic [9:0] wr_x0, wr_y0, wr_x1, wr_y1;
  logic disp_bank, busy, frame_done, overrun;

  always #5 clk = ~clk;

  cube_line_sequencer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .line_num(line_num), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_x1(wr_x1), .wr_y1(wr_y1),
    .disp_bank(disp_bank), .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  // Endpoint table for the engine model, one entry per cube edge.
  function automatic int ep(input int l, input int k);
    case (k)
      0: return l * 7 - 40;
      1: return 30 - l * 5;
      2: return l * 4 - 20;
      default: return l * 9 - 50;
    endcase
  endfunction

  function automatic int px(input int e);
    int v;
    v = 320 + e * 8;
    if (v < 0) v = 0;
    if (v > 639) v = 639;
    return v;
  endfunction

  function automatic int py(input int e);
    int v;
    v = 240 - e * 8;
    if (v < 0) v = 0;
    if (v > 479) v = 479;
    return v;
  endfunction

  // Engine stub selection: 0/1 constant values, 2 behavioural engine.
  int mode = 0;
  logic signed [12:0] cx0 = 0, cy0 = 0, cx1 = 0, cy1 = 0;

  // Behavioural engine: samples LineNum once per 6-cycle round, outputs
  // update 5 cycles after loading.
  int phase = 0;
  logic [3:0] mline = 4'd0;
  logic signed [12:0] mx0 = 0, my0 = 0, mx1 = 0, my1 = 0;
  always @(posedge clk) begin
    phase <= (phase == 5) ? 0 : phase + 1;
    if (phase == 0) mline <= line_num;
    if (phase == 5) begin
      mx0 <= 13'(ep(int'(mline), 0));
      my0 <= 13'(ep(int'(mline), 1));
      mx1 <= 13'(ep(int'(mline), 2));
      my1 <= 13'(ep(int'(mline), 3));
    end
  end

  assign eng_x0 = (mode == 2) ? mx0 : cx0;
  assign eng_y0 = (mode == 2) ? my0 : cy0;
  assign eng_x1 = (mode == 2) ? mx1 : cx1;
  assign eng_y1 = (mode == 2) ? my1 : cy1;

  typedef struct {
    logic [4:0] addr;
    logic [9:0] x0, y0, x1, y1;
    int cyc;
  } wr_t;
  wr_t q[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int base = 0;
  int ndone = 0;
  logic exp_disp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    wr_t it;
    @(posedge clk);
    #1;
    ncyc++;
    if (wr_en === 1'b1) begin
      chk("write_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(it.addr));
        chk("wr_x0", 32'(wr_x0), 32'(it.x0));
        chk("wr_y0", 32'(wr_y0), 32'(it.y0));
        chk("wr_x1", 32'(wr_x1), 32'(it.x1));
        chk("wr_y1", 32'(wr_y1), 32'(it.y1));
        chk("wr_cycle", 32'(ncyc - base), 32'(it.cyc));
      end
    end
    if (frame_done === 1'b1) begin
      ndone++;
      chk("done_cycle", 32'(ncyc - base), 157);
    end
  endtask

  task automatic push_frame(input logic bank);
    wr_t it;
    for (int l = 0; l < 12; l++) begin
      it.addr = {bank, 4'(l)};
      if (mode == 2) begin
        it.x0 = 10'(px(ep(l, 0)));
        it.y0 = 10'(py(ep(l, 1)));
        it.x1 = 10'(px(ep(l, 2)));
        it.y1 = 10'(py(ep(l, 3)));
      end else begin
        it.x0 = 10'(px(int'(cx0)));
        it.y0 = 10'(py(int'(cy0)));
        it.x1 = 10'(px(int'(cx1)));
        it.y1 = 10'(py(int'(cy1)));
      end
      it.cyc = 13 * (l + 1);
      q.push_back(it);
    end
  endtask

  task automatic start_frame();
    base = ncyc;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    chk("line0", 32'(line_num), 0);
  endtask

  // Full frame: ends in cycle 158 (IDLE) ready for a back-to-back start.
  task automatic run_frame();
    int d0;
    logic bank;
    bank = ~exp_disp;
    d0 = ndone;
    push_frame(bank);
    start_frame();
    repeat (157) tick();
    exp_disp = bank;
    chk("done_count", 32'(ndone - d0), 1);
    chk("sb_empty", 32'(q.size()), 0);
    chk("busy_end", 32'(busy), 0);
    chk("disp_bank", 32'(disp_bank), 32'(exp_disp));
  endtask

  task automatic chk_reset_state();
    chk("rst_line_num", 32'(line_num), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_x0", 32'(wr_x0), 0);
    chk("rst_wr_y0", 32'(wr_y0), 0);
    chk("rst_wr_x1", 32'(wr_x1), 0);
    chk("rst_wr_y1", 32'(wr_y1), 0);
    chk("rst_disp_bank", 32'(disp_bank), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_reset_state();

    // Nominal frame: (10,10,10,-10) -> (400,160,400,320) into bank 1
    mode = 0;
    cx0 = 13'sd10; cy0 = 13'sd10; cx1 = 13'sd10; cy1 = -13'sd10;
    run_frame();
    chk("hold_wr_x0", 32'(wr_x0), 400);
    chk("hold_wr_y1", 32'(wr_y1), 320);
    chk("hold_wr_en", 32'(wr_en), 0);

    // Back-to-back at cycle 158 with clamping values -> bank 0
    mode = 1;
    cx0 = 13'sd100; cy0 = -13'sd50; cx1 = -13'sd50; cy1 = 13'sd100;
    run_frame();
    chk("no_overrun_b2b", 32'(overrun), 0);

    // Overrun: second frame_start at cycle 50 must not restart the frame
    mode = 0;
    cx0 = 13'sd10; cy0 = 13'sd10; cx1 = 13'sd10; cy1 = -13'sd10;
    push_frame(~exp_disp);
    start_frame();
    repeat (48) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("overrun_set", 32'(overrun), 1);
    chk("busy_after_overrun", 32'(busy), 1);
    repeat (108) tick();
    exp_disp = ~exp_disp;
    chk("ovr_sb_empty", 32'(q.size()), 0);
    chk("ovr_disp_bank", 32'(disp_bank), 32'(exp_disp));
    chk("ovr_busy_end", 32'(busy), 0);

    // Settle check: engine model with every phase alignment
    mode = 2;
    for (int k = 0; k < 6; k++) begin
      repeat (k) tick();
      run_frame();
    end
    chk("overrun_sticky", 32'(overrun), 1);

    // Reset mid-frame at cycle 60
    mode = 0;
    push_frame(~exp_disp);
    start_frame();
    repeat (58) tick();
    chk("pre_reset_sb", 32'(q.size()), 8);
    reset = 1'b1;
    tick();
    q.delete();
    chk_reset_state();
    reset = 1'b0;
    tick();
    exp_disp = 1'b0;
    run_frame();
    chk("post_reset_bank", 32'(disp_bank), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
